// File: rtl/modarith_pkg.sv
// Shared state encoding and sizing helpers for the chunked
// modular add/subtract datapath.
package modarith_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2,
      DONE   = 2'd3
   } state_t;

   function automatic int ceil_div(input int n, input int d);
      return (n + d - 1) / d;
   endfunction

   // One extra bit so the counter can hold NCHUNK itself.
   function automatic int idx_bits(input int n);
      return $clog2(n) + 1;
   endfunction

   localparam int DEF_WIDTH  = 381;
   localparam int DEF_CHUNK  = 64;
   localparam int DEF_NCHUNK = ceil_div(DEF_WIDTH, DEF_CHUNK);
   localparam int DEF_IDXW   = idx_bits(DEF_NCHUNK);

endpackage

// File: rtl/modaddsub_slice.sv
// One CHUNK-bit slice: raw sum/difference plus its modulus
// correction, each with its own carry/borrow chain.
module modaddsub_slice #(
   parameter int CHUNK = 64
) (
   input  logic [CHUNK-1:0] i_a,
   input  logic [CHUNK-1:0] i_b,
   input  logic [CHUNK-1:0] i_m,
   input  logic             i_subtract,
   input  logic             i_carry_s,
   input  logic             i_carry_t,
   output logic [CHUNK-1:0] o_s,
   output logic [CHUNK-1:0] o_t,
   output logic             o_carry_s,
   output logic             o_carry_t
);

   logic [CHUNK:0] w_s;
   logic [CHUNK:0] w_t;

   // Top bit of each CHUNK+1 result is the carry (add) or borrow (sub).
   always_comb begin
      if (i_subtract) begin
         w_s = {1'b0, i_a} - {1'b0, i_b}
             - (CHUNK+1)'(i_carry_s);
         w_t = {1'b0, w_s[CHUNK-1:0]} + {1'b0, i_m}
             + (CHUNK+1)'(i_carry_t);
      end else begin
         w_s = {1'b0, i_a} + {1'b0, i_b}
             + (CHUNK+1)'(i_carry_s);
         w_t = {1'b0, w_s[CHUNK-1:0]} - {1'b0, i_m}
             - (CHUNK+1)'(i_carry_t);
      end
   end

   assign o_s       = w_s[CHUNK-1:0];
   assign o_t       = w_t[CHUNK-1:0];
   assign o_carry_s = w_s[CHUNK];
   assign o_carry_t = w_t[CHUNK];

endmodule

// File: rtl/modaddsub_chunked.sv
// Multi-cycle modular adder/subtractor, CHUNK bits per cycle,
// with a start/done/busy handshake.
module modaddsub_chunked
   import modarith_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             subtract,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_m,
   output logic [WIDTH-1:0] result,
   output logic             done,
   output logic             busy
);

   localparam int NCHUNK = ceil_div(WIDTH, CHUNK);
   localparam int PW     = NCHUNK * CHUNK;
   localparam int IDXW   = idx_bits(NCHUNK);
   localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_load;
   logic              w_step;
   logic              w_fin;

   logic [PW-1:0]     r_a;
   logic [PW-1:0]     r_b;
   logic [PW-1:0]     r_m;
   logic [PW-1:0]     r_s;
   logic [PW-1:0]     r_t;
   logic              r_sub;
   logic              r_carry_s;
   logic              r_carry_t;
   logic [IDXW-1:0]   r_idx;

   logic [CHUNK-1:0]  w_s;
   logic [CHUNK-1:0]  w_t;
   logic              w_carry_s;
   logic              w_carry_t;
   logic              w_pick_t;
   logic [WIDTH-1:0]  w_sel;

   modaddsub_slice #(
      .CHUNK (CHUNK)
   ) u_slice (
      .i_a        (r_a[CHUNK-1:0]),
      .i_b        (r_b[CHUNK-1:0]),
      .i_m        (r_m[CHUNK-1:0]),
      .i_subtract (r_sub),
      .i_carry_s  (r_carry_s),
      .i_carry_t  (r_carry_t),
      .o_s        (w_s),
      .o_t        (w_t),
      .o_carry_s  (w_carry_s),
      .o_carry_t  (w_carry_t)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_fin       = 1'b0;
      busy        = 1'b0;
      unique case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = RUN;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         RUN: begin
            busy   = 1'b1;
            w_step = 1'b1;
            if (r_idx == LAST) begin
               w_state_nxt = FINISH;
            end
         end
         FINISH: begin
            busy        = 1'b1;
            w_fin       = 1'b1;
            w_state_nxt = DONE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Add: take s-m when a+b >= m. Sub: take s+m when a-b borrowed.
   always_comb begin
      if (r_sub) begin
         w_pick_t = r_carry_s;
      end else begin
         w_pick_t = r_carry_s | ~r_carry_t;
      end
      w_sel = w_pick_t ? r_t[WIDTH-1:0] : r_s[WIDTH-1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a       <= '0;
         r_b       <= '0;
         r_m       <= '0;
         r_s       <= '0;
         r_t       <= '0;
         r_sub     <= 1'b0;
         r_carry_s <= 1'b0;
         r_carry_t <= 1'b0;
         r_idx     <= '0;
         result    <= '0;
         done      <= 1'b0;
      end else begin
         if (w_load) begin
            r_a       <= PW'(in_a);
            r_b       <= PW'(in_b);
            r_m       <= PW'(in_m);
            r_sub     <= subtract;
            r_carry_s <= 1'b0;
            r_carry_t <= 1'b0;
            r_idx     <= '0;
         end else if (w_step) begin
            r_a       <= r_a >> CHUNK;
            r_b       <= r_b >> CHUNK;
            r_m       <= r_m >> CHUNK;
            r_s       <= (r_s >> CHUNK)
                       | (PW'(w_s) << (PW - CHUNK));
            r_t       <= (r_t >> CHUNK)
                       | (PW'(w_t) << (PW - CHUNK));
            r_carry_s <= w_carry_s;
            r_carry_t <= w_carry_t;
            r_idx     <= r_idx + IDXW'(1);
         end
         if (w_fin) begin
            result <= w_sel;
         end
         done <= w_fin;
      end
   end

endmodule

// File: tb/tb_modaddsub_chunked.sv
// Self-checking bench: five configurations against a
// cycle-level behavioural model plus literal vectors.
module tb_modaddsub_chunked;

   localparam int NI = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic [4:0]    st;
   logic [4:0]    sb;
   logic [380:0]  ia [NI];
   logic [380:0]  ib [NI];
   logic [380:0]  im [NI];
   logic [15:0]   r0;
   logic [380:0]  r1, r2, r3, r4;
   wire  [4:0]    od;
   wire  [4:0]    ob;
   logic [380:0]  ores [NI];

   int errors = 0;
   int checks = 0;

   int            cnt   [NI];
   logic [383:0]  pend  [NI];
   logic [383:0]  mres  [NI];
   logic          mdone [NI];

   always #5 clk = ~clk;

   always_comb begin
      ores[0] = {365'd0, r0};
      ores[1] = r1;
      ores[2] = r2;
      ores[3] = r3;
      ores[4] = r4;
   end

   modaddsub_chunked #(.WIDTH(16), .CHUNK(4)) u0 (
      .clk(clk), .reset(rst), .start(st[0]),
      .subtract(sb[0]), .in_a(ia[0][15:0]),
      .in_b(ib[0][15:0]), .in_m(im[0][15:0]),
      .result(r0), .done(od[0]), .busy(ob[0]));

   modaddsub_chunked #(.WIDTH(381), .CHUNK(64)) u1 (
      .clk(clk), .reset(rst), .start(st[1]),
      .subtract(sb[1]), .in_a(ia[1]), .in_b(ib[1]),
      .in_m(im[1]), .result(r1), .done(od[1]),
      .busy(ob[1]));

   modaddsub_chunked #(.WIDTH(381), .CHUNK(1)) u2 (
      .clk(clk), .reset(rst), .start(st[2]),
      .subtract(sb[2]), .in_a(ia[2]), .in_b(ib[2]),
      .in_m(im[2]), .result(r2), .done(od[2]),
      .busy(ob[2]));

   modaddsub_chunked #(.WIDTH(381), .CHUNK(127)) u3 (
      .clk(clk), .reset(rst), .start(st[3]),
      .subtract(sb[3]), .in_a(ia[3]), .in_b(ib[3]),
      .in_m(im[3]), .result(r3), .done(od[3]),
      .busy(ob[3]));

   modaddsub_chunked #(.WIDTH(381), .CHUNK(381)) u4 (
      .clk(clk), .reset(rst), .start(st[4]),
      .subtract(sb[4]), .in_a(ia[4]), .in_b(ib[4]),
      .in_m(im[4]), .result(r4), .done(od[4]),
      .busy(ob[4]));

   function automatic int nch(input int k);
      case (k)
         0:       return 4;
         1:       return 6;
         2:       return 381;
         3:       return 3;
         default: return 1;
      endcase
   endfunction

   function automatic int wid(input int k);
      return (k == 0) ? 16 : 381;
   endfunction

   // Plain modular arithmetic, truncated to the instance width.
   function automatic logic [383:0] ref_op(
      input logic sub, input logic [383:0] a,
      input logic [383:0] b, input logic [383:0] m,
      input int w);
      logic [383:0] mask;
      logic [383:0] r;
      mask = (384'd1 << w) - 384'd1;
      a = a & mask;
      b = b & mask;
      m = m & mask;
      if (!sub) begin
         r = a + b;
         if (r >= m) r = r - m;
      end else begin
         if (a >= b) r = a - b;
         else        r = a - b + m;
      end
      return r & mask;
   endfunction

   function automatic logic [383:0] rndw();
      logic [383:0] r;
      r = '0;
      for (int i = 0; i < 12; i++) begin
         r = {r[351:0], 32'($urandom)};
      end
      return r & ((384'd1 << 381) - 384'd1);
   endfunction

   task automatic chk(input string nm,
                      input logic [383:0] act,
                      input logic [383:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
      end
   endtask

   // Model: accept on an idle cycle, result and done NCHUNK+1 edges later.
   always @(posedge clk or posedge rst) begin
      for (int k = 0; k < NI; k++) begin
         if (rst) begin
            cnt[k]   = 0;
            mres[k]  = '0;
            mdone[k] = 1'b0;
            pend[k]  = '0;
         end else begin
            mdone[k] = 1'b0;
            if (cnt[k] > 0) begin
               cnt[k] = cnt[k] - 1;
               if (cnt[k] == 0) begin
                  mdone[k] = 1'b1;
                  mres[k]  = pend[k];
               end
            end else if (st[k]) begin
               pend[k] = ref_op(sb[k], 384'(ia[k]),
                                384'(ib[k]), 384'(im[k]),
                                wid(k));
               cnt[k]  = nch(k) + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("busy%0d", k),
             384'(ob[k]), 384'(cnt[k] > 0));
         chk($sformatf("done%0d", k),
             384'(od[k]), 384'(mdone[k]));
         chk($sformatf("result%0d", k),
             384'(ores[k]), mres[k]);
      end
   end

   task automatic do_op(input int k, input logic sub,
                        input logic [380:0] a,
                        input logic [380:0] b,
                        input logic [380:0] m,
                        input logic [383:0] exp,
                        input int lat, input string nm);
      int  n;
      bit  seen;
      @(negedge clk);
      ia[k] = a;
      ib[k] = b;
      im[k] = m;
      sb[k] = sub;
      st[k] = 1'b1;
      @(posedge clk);
      #1 st[k] = 1'b0;
      seen = 0;
      n    = 0;
      while (!seen && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
         if (od[k]) seen = 1;
      end
      chk({nm, "_lat"}, 384'(n), 384'(lat));
      chk({nm, "_res"}, 384'(ores[k]), exp);
   endtask

   logic [380:0] m381;
   int           dones;
   bit           seen;
   bit           idle;

   initial begin
      rst = 1'b1;
      st  = '0;
      sb  = '0;
      for (int k = 0; k < NI; k++) begin
         ia[k] = '0;
         ib[k] = '0;
         im[k] = 381'd1;
      end
      m381 = (381'd1 << 380) + 381'h1D;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_result", 384'(ores[1]), 384'd0);
      chk("rst_done", 384'(od), 384'd0);
      chk("rst_busy", 384'(ob), 384'd0);
      @(negedge clk);
      rst = 1'b0;

      do_op(0, 1'b0, 381'hFFF0, 381'h0005, 381'hFFF1,
            384'h0004, 5, "add16");
      do_op(0, 1'b1, 381'h0003, 381'h0005, 381'hFFF1,
            384'hFFEF, 5, "sub16_neg");
      do_op(0, 1'b1, 381'h0005, 381'h0003, 381'hFFF1,
            384'h0002, 5, "sub16_pos");
      do_op(0, 1'b1, 381'h1234, 381'h1234, 381'hFFF1,
            384'h0000, 5, "sub16_eq");
      do_op(1, 1'b0, m381 - 381'd1, 381'd1, m381,
            384'd0, 7, "add381");
      do_op(1, 1'b1, 381'd0, 381'd1, m381,
            384'(m381 - 381'd1), 7, "sub381");
      do_op(4, 1'b0, m381 - 381'd1, 381'd1, m381,
            384'd0, 2, "add381_c381");
      do_op(3, 1'b1, 381'd0, 381'd1, m381,
            384'(m381 - 381'd1), 4, "sub381_c127");

      // Start held high, operands scrambled during the run.
      @(negedge clk);
      ia[0] = 381'h1234;
      ib[0] = 381'h4321;
      im[0] = 381'hFFF1;
      sb[0] = 1'b0;
      st[0] = 1'b1;
      @(posedge clk);
      dones = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         ia[0] = 381'($urandom_range(0, 65535));
         ib[0] = 381'($urandom_range(0, 65535));
         im[0] = 381'($urandom_range(1, 65535));
         sb[0] = 1'($urandom);
         @(posedge clk);
         #1;
         if (od[0]) dones++;
      end
      chk("hold_res", 384'(ores[0]), 384'h5555);
      chk("hold_dones", 384'(dones), 384'd1);
      @(posedge clk);
      #1;
      chk("hold_relaunch", 384'(ob[0]), 384'd1);
      st[0] = 1'b0;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (od[0]) seen = 1;
      end
      chk("hold_second_done", 384'(seen), 384'd1);

      // Abort in the middle of the run.
      @(negedge clk);
      ia[0] = 381'hFFF0;
      ib[0] = 381'h0005;
      im[0] = 381'hFFF1;
      sb[0] = 1'b0;
      st[0] = 1'b1;
      @(posedge clk);
      #1 st[0] = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_result", 384'(ores[0]), 384'd0);
      chk("abort_busy", 384'(ob[0]), 384'd0);
      chk("abort_done", 384'(od[0]), 384'd0);
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (od[0]) dones++;
      end
      chk("abort_no_done", 384'(dones), 384'd0);
      do_op(0, 1'b0, 381'hFFF0, 381'h0005, 381'hFFF1,
            384'h0004, 5, "after_abort");

      // Random operands below m on the four 381-bit instances.
      for (int c = 0; c < 12000; c++) begin
         @(negedge clk);
         for (int k = 1; k < NI; k++) begin
            if (cnt[k] == 0) begin
               logic [383:0] m;
               m = rndw();
               if (m == '0) m = 384'd1;
               im[k] = 381'(m);
               ia[k] = 381'(rndw() % m);
               ib[k] = 381'(rndw() % m);
               sb[k] = 1'($urandom);
               st[k] = 1'b1;
            end else begin
               st[k] = 1'b0;
            end
         end
      end
      @(negedge clk);
      st = '0;
      idle = 0;
      for (int i = 0; i < 1000 && !idle; i++) begin
         @(negedge clk);
         idle = 1;
         for (int k = 0; k < NI; k++) begin
            if (cnt[k] != 0) idle = 0;
         end
      end
      chk("drain", 384'(idle), 384'd1);
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule
